// File: rtl/ysyx_23060221_axi_pkg.sv
// Shared AXI encodings, channel FSM state types and burst address helper for the SRAM slave.
package ysyx_23060221_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

  // WRAP is handled as INCR; only FIXED holds the address.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic fixed);
    return fixed ? addr : addr + 32'd4;
  endfunction

endpackage

// File: rtl/ysyx_23060221_axi_sram_if.sv
// AXI4 (32-bit data, 4-bit id) bus bundle between a core-side master and the SRAM slave.
interface ysyx_23060221_axi_sram_if;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );
endinterface

// File: rtl/ysyx_23060221_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), free-running every cycle; supplies latency jitter.
module ysyx_23060221_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= seed;
    else      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end
endmodule

// File: rtl/ysyx_23060221_axi_sram.sv
// AXI4 slave SRAM with independent read/write FSMs, fixed latency plus optional LFSR jitter.
// One read and one write outstanding; R/B outputs held stable until the master accepts them.
module ysyx_23060221_axi_sram
  import ysyx_23060221_axi_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          RD_LAT    = 1,
  parameter int          WR_LAT    = 1,
  parameter int          RAND_EN   = 0,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input logic clk,
  input logic rst,
  ysyx_23060221_axi_sram_if.slave bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  function automatic logic hit(input logic [31:0] a);
    return (a - BASE) < SPAN;
  endfunction

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return off[AW-1:0];
  endfunction

  logic [31:0] mem [DEPTH];
  logic [7:0]  lfsr_q, rnd, wr_load, rd_load;

  ysyx_23060221_lfsr8 u_lfsr (.clk(clk), .rst(rst), .seed(LFSR_SEED), .q(lfsr_q));

  assign rnd     = (RAND_EN != 0) ? {5'd0, lfsr_q[2:0]} : 8'd0;
  assign wr_load = 8'(WR_LAT - 1) + rnd;
  assign rd_load = 8'(RD_LAT - 1) + rnd;

  wr_state_t   w_state, w_nxt;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_cnt;
  logic [8:0]  w_beats;
  logic        w_fixed, w_dec, w_hs, w_ok;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  assign w_hs = (w_state == W_DATA) && bus.wvalid;
  assign w_ok = hit(w_addr);

  always_comb begin
    w_nxt = w_state;
    case (w_state)
      W_IDLE:  if (bus.awvalid) w_nxt = W_DATA;
      W_DATA:  if (bus.wvalid && bus.wlast) w_nxt = (wr_load == 8'd0) ? W_RESP : W_WAIT;
      W_WAIT:  if (w_cnt <= 8'd1) w_nxt = W_RESP;
      W_RESP:  if (bus.bready) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_fixed <= 1'b0;
      w_beats <= '0;
      w_dec   <= 1'b0;
      w_cnt   <= '0;
      b_resp  <= RESP_OKAY;
      b_id    <= '0;
    end else begin
      w_state <= w_nxt;
      if (w_state == W_IDLE && bus.awvalid) begin
        w_addr  <= bus.awaddr;
        w_len   <= bus.awlen;
        w_fixed <= (bus.awburst == BURST_FIXED);
        b_id    <= bus.awid;
        w_beats <= '0;
        w_dec   <= 1'b0;
      end
      if (w_hs) begin
        w_addr  <= next_addr(w_addr, w_fixed);
        w_beats <= w_beats + 9'd1;
        w_dec   <= w_dec | ~w_ok;
        if (bus.wlast) begin
          w_cnt  <= wr_load;
          // Decode error outranks a beat-count mismatch.
          b_resp <= (w_dec || !w_ok) ? RESP_DECERR :
                    (w_beats != {1'b0, w_len}) ? RESP_SLVERR : RESP_OKAY;
        end
      end
      if (w_state == W_WAIT) w_cnt <= w_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && w_ok) begin
      for (int i = 0; i < 4; i++)
        if (bus.wstrb[i]) mem[widx(w_addr)][8*i +: 8] <= bus.wdata[8*i +: 8];
    end
  end

  rd_state_t   r_state, r_nxt;
  logic [31:0] r_addr, rd_sel, rdata_q;
  logic [7:0]  r_len, r_beat, r_cnt, cap_len, cap_beat;
  logic        r_fixed, rd_cap, rlast_q;
  logic [1:0]  rresp_q;
  logic [3:0]  rid_q;

  // rd_sel is the address of the beat being loaded into the output register this cycle.
  always_comb begin
    r_nxt    = r_state;
    rd_sel   = r_addr;
    cap_len  = r_len;
    cap_beat = 8'd0;
    rd_cap   = 1'b0;
    case (r_state)
      R_IDLE: begin
        rd_sel  = bus.araddr;
        cap_len = bus.arlen;
        rd_cap  = bus.arvalid && (rd_load == 8'd0);
        if (bus.arvalid) r_nxt = (rd_load == 8'd0) ? R_DATA : R_WAIT;
      end
      R_WAIT: begin
        rd_cap = (r_cnt <= 8'd1);
        if (r_cnt <= 8'd1) r_nxt = R_DATA;
      end
      R_DATA: begin
        rd_sel   = next_addr(r_addr, r_fixed);
        cap_beat = r_beat + 8'd1;
        rd_cap   = bus.rready && !rlast_q;
        if (bus.rready && rlast_q) r_nxt = R_IDLE;
      end
      default: r_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_fixed <= 1'b0;
      r_beat  <= '0;
      r_cnt   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      rlast_q <= 1'b0;
      rid_q   <= '0;
    end else begin
      r_state <= r_nxt;
      if (r_state == R_IDLE && bus.arvalid) begin
        r_addr  <= bus.araddr;
        r_len   <= bus.arlen;
        r_fixed <= (bus.arburst == BURST_FIXED);
        rid_q   <= bus.arid;
        r_beat  <= '0;
        r_cnt   <= rd_load;
      end
      if (r_state == R_WAIT) r_cnt <= r_cnt - 8'd1;
      if (r_state == R_DATA && bus.rready && !rlast_q) begin
        r_addr <= rd_sel;
        r_beat <= cap_beat;
      end
      if (rd_cap) begin
        rdata_q <= hit(rd_sel) ? mem[widx(rd_sel)] : 32'd0;
        rresp_q <= hit(rd_sel) ? RESP_OKAY : RESP_DECERR;
        rlast_q <= (cap_beat == cap_len);
      end else if (r_state == R_DATA && bus.rready) begin
        rlast_q <= 1'b0;
      end
    end
  end

  assign bus.awready = (w_state == W_IDLE);
  assign bus.wready  = (w_state == W_DATA);
  assign bus.bvalid  = (w_state == W_RESP);
  assign bus.bresp   = b_resp;
  assign bus.bid     = b_id;
  assign bus.arready = (r_state == R_IDLE);
  assign bus.rvalid  = (r_state == R_DATA);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;
  assign bus.rid     = rid_q;
endmodule

// File: tb/tb_ysyx_23060221_axi_sram.sv
// Directed bench for the AXI SRAM: fixed-latency instance plus a jittered-latency instance.
module tb_ysyx_23060221_axi_sram;
  import ysyx_23060221_axi_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060221_axi_sram_if bus ();
  ysyx_23060221_axi_sram_if rbus ();

  ysyx_23060221_axi_sram dut (.clk(clk), .rst(rst), .bus(bus));
  ysyx_23060221_axi_sram #(.RD_LAT(2), .WR_LAT(2), .RAND_EN(1)) rdut (.clk(clk), .rst(rst), .bus(rbus));

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    {bus.awvalid, bus.awaddr, bus.awid, bus.awlen, bus.awsize, bus.awburst} = '0;
    {bus.wvalid, bus.wdata, bus.wstrb, bus.wlast, bus.bready} = '0;
    {bus.arvalid, bus.araddr, bus.arid, bus.arlen, bus.arsize, bus.arburst, bus.rready} = '0;
    {rbus.awvalid, rbus.awaddr, rbus.awid, rbus.awlen, rbus.awsize, rbus.awburst} = '0;
    {rbus.wvalid, rbus.wdata, rbus.wstrb, rbus.wlast, rbus.bready} = '0;
    {rbus.arvalid, rbus.araddr, rbus.arid, rbus.arlen, rbus.arsize, rbus.arburst, rbus.rready} = '0;
  endtask

  // Single-beat write; lat counts cycles from W handshake to bvalid seen (-1 on timeout).
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    int n = 0, w_at = 0;
    bit done = 0, aw_hs, w_hs;
    resp = 'x; lat = -1;
    bus.awvalid = 1; bus.awaddr = a; bus.awid = 4'h3; bus.awlen = 0; bus.awsize = 3'd2;
    bus.awburst = BURST_INCR; bus.wvalid = 1; bus.wdata = d; bus.wstrb = s; bus.wlast = 1;
    bus.bready = 1;
    while (!done && n < 60) begin
      if (bus.bvalid && bus.bready) begin resp = bus.bresp; lat = n - w_at; done = 1; end
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      if (w_hs) w_at = n;
      tick(); n++;
      if (aw_hs) bus.awvalid = 0;
      if (w_hs) bus.wvalid = 0;
    end
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output logic last, output logic [3:0] id, output int lat);
    int n = 0, ar_at = 0;
    bit done = 0, ar_hs;
    d = 'x; resp = 'x; last = 'x; id = 'x; lat = -1;
    bus.arvalid = 1; bus.araddr = a; bus.arid = 4'h9; bus.arlen = 0; bus.arsize = 3'd2;
    bus.arburst = BURST_INCR; bus.rready = 1;
    while (!done && n < 60) begin
      if (bus.rvalid && bus.rready) begin
        d = bus.rdata; resp = bus.rresp; last = bus.rlast; id = bus.rid; lat = n - ar_at; done = 1;
      end
      ar_hs = bus.arvalid && bus.arready;
      if (ar_hs) ar_at = n;
      tick(); n++;
      if (ar_hs) bus.arvalid = 0;
    end
    bus.arvalid = 0; bus.rready = 0;
  endtask

  task automatic r_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [1:0] resp, output int lat);
    int n = 0, w_at = 0;
    bit done = 0, aw_hs, w_hs;
    resp = 'x; lat = -1;
    rbus.awvalid = 1; rbus.awaddr = a; rbus.awid = 4'h1; rbus.awlen = 0; rbus.awsize = 3'd2;
    rbus.awburst = BURST_INCR; rbus.wvalid = 1; rbus.wdata = d; rbus.wstrb = s; rbus.wlast = 1;
    rbus.bready = 1;
    while (!done && n < 60) begin
      if (rbus.bvalid && rbus.bready) begin resp = rbus.bresp; lat = n - w_at; done = 1; end
      aw_hs = rbus.awvalid && rbus.awready;
      w_hs  = rbus.wvalid && rbus.wready;
      if (w_hs) w_at = n;
      tick(); n++;
      if (aw_hs) rbus.awvalid = 0;
      if (w_hs) rbus.wvalid = 0;
    end
    rbus.awvalid = 0; rbus.wvalid = 0; rbus.bready = 0;
  endtask

  task automatic r_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                        output int lat);
    int n = 0, ar_at = 0;
    bit done = 0, ar_hs;
    d = 'x; resp = 'x; lat = -1;
    rbus.arvalid = 1; rbus.araddr = a; rbus.arid = 4'h2; rbus.arlen = 0; rbus.arsize = 3'd2;
    rbus.arburst = BURST_INCR; rbus.rready = 1;
    while (!done && n < 60) begin
      if (rbus.rvalid && rbus.rready) begin
        d = rbus.rdata; resp = rbus.rresp; lat = n - ar_at; done = 1;
      end
      ar_hs = rbus.arvalid && rbus.arready;
      if (ar_hs) ar_at = n;
      tick(); n++;
      if (ar_hs) rbus.arvalid = 0;
    end
    rbus.arvalid = 0; rbus.rready = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 0;
    repeat (3) tick();
    rst = 1;
    tick();
    total_cnt++;
    if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast} !== 6'b110000)
      $display("FAIL reset_ctrl got %b exp 110000",
               {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast});
    else pass_cnt++;
    total_cnt++;
    if ({bus.rdata, bus.rresp, bus.bresp, bus.rid, bus.bid} !== 44'd0)
      $display("FAIL reset_data got %h exp 0", {bus.rdata, bus.rresp, bus.bresp, bus.rid, bus.bid});
    else pass_cnt++;
  endtask

  task automatic test_write_read;
    logic [1:0] resp; logic [31:0] d; logic last; logic [3:0] id; int lat;
    do_write(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, resp, lat);
    total_cnt++;
    if (resp !== RESP_OKAY || lat !== 1) $display("FAIL wr_basic got resp %b lat %0d exp 00 lat 1", resp, lat);
    else pass_cnt++;
    total_cnt++;
    if (bus.awready !== 1'b1) $display("FAIL awready_after_b got %b exp 1", bus.awready);
    else pass_cnt++;
    do_read(BASE + 32'h4, d, resp, last, id, lat);
    total_cnt++;
    if (d !== 32'hDEAD_BEEF || resp !== RESP_OKAY) $display("FAIL rd_basic got %h/%b exp deadbeef/00", d, resp);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 1 || last !== 1'b1 || id !== 4'h9)
      $display("FAIL rd_timing got lat %0d last %b id %h exp 1 1 9", lat, last, id);
    else pass_cnt++;
  endtask

  task automatic test_byte_store;
    logic [1:0] resp; logic [31:0] d; logic last; logic [3:0] id; int lat;
    do_write(BASE + 32'h8, 32'h1122_3344, 4'hF, resp, lat);
    do_write(BASE + 32'h8, 32'h0000_AA00, 4'b0010, resp, lat);
    do_read(BASE + 32'h8, d, resp, last, id, lat);
    total_cnt++;
    if (d !== 32'h1122_AA44) $display("FAIL byte_store got %h exp 1122aa44", d);
    else pass_cnt++;
    do_write(BASE + 32'h8, 32'hCC00_00DD, 4'b1001, resp, lat);
    do_read(BASE + 32'h8, d, resp, last, id, lat);
    total_cnt++;
    if (d !== 32'hCC22_AADD) $display("FAIL byte_store2 got %h exp cc22aadd", d);
    else pass_cnt++;
  endtask

  task automatic test_burst_read;
    logic [1:0] resp; int lat, beats = 0, n = 0, bad = 0;
    logic [31:0] got [4]; logic [3:0] lasts = '0; logic [32:0] held = '0;
    bit stalled = 0, tgl = 1, ar_hs;
    for (int i = 0; i < 4; i++) do_write(BASE + 32'(4 * i), 32'h1000_0000 + 32'(i * 32'h111), 4'hF, resp, lat);
    bus.arvalid = 1; bus.araddr = BASE; bus.arid = 4'h6; bus.arlen = 8'd3; bus.arsize = 3'd2;
    bus.arburst = BURST_INCR;
    while (beats < 4 && n < 60) begin
      bus.rready = tgl; tgl = ~tgl;
      if (bus.rvalid) begin
        if (stalled && {bus.rlast, bus.rdata} !== held) bad++;
        if (bus.rready) begin
          got[beats] = bus.rdata; lasts[beats] = bus.rlast; beats++; stalled = 0;
        end else begin
          stalled = 1; held = {bus.rlast, bus.rdata};
        end
      end
      ar_hs = bus.arvalid && bus.arready;
      tick(); n++;
      if (ar_hs) bus.arvalid = 0;
    end
    bus.rready = 0;
    total_cnt++;
    if (bus.rvalid !== 1'b0) $display("FAIL burst_end_rvalid got %b exp 0", bus.rvalid);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (got[i] !== 32'h1000_0000 + 32'(i * 32'h111))
        $display("FAIL burst_beat%0d got %h exp %h", i, got[i], 32'h1000_0000 + 32'(i * 32'h111));
      else pass_cnt++;
    end
    total_cnt++;
    if (lasts !== 4'b1000) $display("FAIL burst_rlast got %b exp 1000", lasts);
    else pass_cnt++;
    total_cnt++;
    if (bad !== 0) $display("FAIL burst_stall_stable got %0d changes exp 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_decerr;
    logic [1:0] resp; logic [31:0] d; logic last; logic [3:0] id; int lat;
    do_write(BASE + 32'hFFC, 32'h5A5A_5A5A, 4'hF, resp, lat);
    do_read(32'h7FFF_FFFC, d, resp, last, id, lat);
    total_cnt++;
    if (resp !== RESP_DECERR || d !== 32'd0) $display("FAIL rd_decerr got %b/%h exp 11/0", resp, d);
    else pass_cnt++;
    do_write(32'h9000_0000, 32'h55AA_55AA, 4'hF, resp, lat);
    total_cnt++;
    if (resp !== RESP_DECERR) $display("FAIL wr_decerr got %b exp 11", resp);
    else pass_cnt++;
    do_read(BASE, d, resp, last, id, lat);
    total_cnt++;
    if (d !== 32'h1000_0000) $display("FAIL wr_decerr_nowrite got %h exp 10000000", d);
    else pass_cnt++;
    do_write(BASE + 32'h3FFC, 32'h0BAD_F00D, 4'hF, resp, lat);
    do_read(BASE + 32'h3FFC, d, resp, last, id, lat);
    total_cnt++;
    if (d !== 32'h0BAD_F00D || resp !== RESP_OKAY) $display("FAIL top_word got %h/%b exp 0badf00d/00", d, resp);
    else pass_cnt++;
    do_read(BASE + 32'h4000, d, resp, last, id, lat);
    total_cnt++;
    if (resp !== RESP_DECERR) $display("FAIL past_end got %b exp 11", resp);
    else pass_cnt++;
  endtask

  task automatic test_slverr;
    logic [1:0] resp; logic [31:0] d; logic last; logic [3:0] id; int lat, n = 0, bad = 0;
    logic got_b; logic [5:0] first; bit aw_hs, w_hs;
    bus.awvalid = 1; bus.awaddr = BASE + 32'h20; bus.awid = 4'h5; bus.awlen = 8'd1;
    bus.awburst = BURST_INCR; bus.wvalid = 1; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
    bus.wlast = 1; bus.bready = 0;
    while (!bus.bvalid && n < 30) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick(); n++;
      if (aw_hs) bus.awvalid = 0;
      if (w_hs) bus.wvalid = 0;
    end
    bus.awvalid = 0; bus.wvalid = 0;
    got_b = bus.bvalid; first = {bus.bresp, bus.bid};
    repeat (5) begin
      tick();
      if (!bus.bvalid || {bus.bresp, bus.bid} !== first) bad++;
    end
    bus.bready = 1;
    tick();
    bus.bready = 0;
    total_cnt++;
    if (got_b !== 1'b1 || first !== {RESP_SLVERR, 4'h5}) $display("FAIL slverr got v%b %h exp v1 25", got_b, first);
    else pass_cnt++;
    total_cnt++;
    if (bad !== 0) $display("FAIL b_stall_stable got %0d changes exp 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (bus.bvalid !== 1'b0) $display("FAIL b_release got %b exp 0", bus.bvalid);
    else pass_cnt++;
    do_read(BASE + 32'h20, d, resp, last, id, lat);
    total_cnt++;
    if (d !== 32'h1234_5678) $display("FAIL short_burst_data got %h exp 12345678", d);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    bus.arvalid = 1; bus.araddr = BASE; bus.arlen = 8'd3; bus.arburst = BURST_INCR; bus.rready = 0;
    bus.awvalid = 1; bus.awaddr = BASE + 32'h24; bus.awlen = 8'd0; bus.wvalid = 0; bus.bready = 1;
    rbus.awvalid = 1; rbus.awaddr = BASE + 32'h40; rbus.awlen = 8'd0; rbus.awburst = BURST_INCR;
    rbus.wvalid = 1; rbus.wdata = 32'h7777_7777; rbus.wstrb = 4'hF; rbus.wlast = 1; rbus.bready = 1;
    tick();
    bus.arvalid = 0; bus.awvalid = 0; rbus.awvalid = 0;
    tick();
    rbus.wvalid = 0;
    total_cnt++;
    if ({bus.rvalid, bus.wready, rbus.awready, rbus.wready, rbus.bvalid} !== 5'b11000)
      $display("FAIL pre_reset_state got %b exp 11000",
               {bus.rvalid, bus.wready, rbus.awready, rbus.wready, rbus.bvalid});
    else pass_cnt++;
    #2 rst = 0;
    #1;
    total_cnt++;
    if ({bus.rvalid, bus.bvalid, bus.arready, bus.awready, bus.wready, rbus.bvalid, rbus.awready} !== 7'b0011001)
      $display("FAIL async_reset got %b exp 0011001",
               {bus.rvalid, bus.bvalid, bus.arready, bus.awready, bus.wready, rbus.bvalid, rbus.awready});
    else pass_cnt++;
    idle_inputs();
    bus.rready = 1; bus.bready = 1; rbus.bready = 1;
    tick();
    rst = 1;
    repeat (12) begin
      tick();
      if (bus.rvalid || bus.bvalid || rbus.bvalid) seen++;
    end
    bus.rready = 0; bus.bready = 0; rbus.bready = 0;
    total_cnt++;
    if (seen !== 0) $display("FAIL abandoned_resp got %0d cycles exp 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [31:0] model [16]; logic [31:0] d, wd, m; logic [3:0] s; logic [1:0] resp; int lat, k;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      r_write(BASE + 32'h100 + 32'(4 * i), model[i], 4'hF, resp, lat);
      total_cnt++;
      if (resp !== RESP_OKAY || lat < 2 || lat > 9) $display("FAIL rnd_init%0d got %b lat %0d exp 00 lat 2..9", i, resp, lat);
      else pass_cnt++;
    end
    for (int t = 0; t < 84; t++) begin
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0) begin
        wd = $urandom; s = 4'($urandom_range(1, 15));
        m = model[k];
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = wd[8*b +: 8];
        model[k] = m;
        r_write(BASE + 32'h100 + 32'(4 * k), wd, s, resp, lat);
        total_cnt++;
        if (resp !== RESP_OKAY || lat < 2 || lat > 9) $display("FAIL rnd_wr%0d got %b lat %0d exp 00 lat 2..9", t, resp, lat);
        else pass_cnt++;
      end else begin
        r_read(BASE + 32'h100 + 32'(4 * k), d, resp, lat);
        total_cnt++;
        if (d !== model[k] || resp !== RESP_OKAY || lat < 2 || lat > 9)
          $display("FAIL rnd_rd%0d got %h/%b lat %0d exp %h/00 lat 2..9", t, d, resp, lat, model[k]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_store();
    test_burst_read();
    test_decerr();
    test_slverr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
